// File: rtl/micro_bus_initiator.sv
// Single-outstanding command-to-bus initiator: one command in, one bus transfer, one response out.
// Optional timeout watchdog is compiled in when MICRO_BUS_TIMEOUT_EN is defined.
module micro_bus_initiator #(
  parameter int WIDTHD  = 32,
  parameter int WIDTHA  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              clock_sreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [WIDTHA-1:0] cmd_address,
  input  logic [WIDTHD-1:0] cmd_writedata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTHD-1:0] rsp_readdata,
  output logic              rsp_error,
  output logic [WIDTHA-1:0] address,
  output logic [WIDTHD-1:0] writedata,
  input  logic [WIDTHD-1:0] readdata,
  output logic              read,
  output logic              write,
  input  logic              waitrequest
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
    $error("micro_bus_initiator: TIMEOUT must be within 1..65535");
  end

  logic [1:0]        state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              dir_write_q, dir_write_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [WIDTHA-1:0] address_q, address_d;
  logic [WIDTHD-1:0] writedata_q, writedata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTHD-1:0] rsp_readdata_q, rsp_readdata_d;
  logic              timeout_s;

`ifdef MICRO_BUS_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT);
  logic [15:0] count_q, count_d, count_inc_s;
  logic        rsp_error_q, rsp_error_d;

  assign count_inc_s = count_q + 16'd1;

  // A stalled cycle that brings the count to the limit aborts; an unstalled cycle always completes.
  always_comb begin
    count_d     = count_q;
    rsp_error_d = rsp_error_q;
    timeout_s   = 1'b0;
    if ((state_q == ST_IDLE) && cmd_valid && cmd_ready_q) begin
      count_d = 16'd0;
    end else if ((state_q == ST_BUS) && waitrequest) begin
      count_d   = count_inc_s;
      timeout_s = (count_inc_s == TIMEOUT_LIM);
    end else begin
      count_d = count_q;
    end
    if ((state_q == ST_BUS) && (!waitrequest || timeout_s)) begin
      rsp_error_d = waitrequest;
    end else begin
      rsp_error_d = rsp_error_q;
    end
  end

  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      count_q     <= 16'd0;
      rsp_error_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign rsp_error = rsp_error_q;
`else
  assign timeout_s = 1'b0;
  assign rsp_error = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    cmd_ready_d    = cmd_ready_q;
    dir_write_d    = dir_write_q;
    read_d         = read_q;
    write_d        = write_q;
    address_d      = address_q;
    writedata_d    = writedata_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_readdata_d = rsp_readdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = ST_BUS;
          cmd_ready_d = 1'b0;
          dir_write_d = cmd_write;
          read_d      = ~cmd_write;
          write_d     = cmd_write;
          address_d   = cmd_address;
          writedata_d = cmd_writedata;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (!waitrequest) begin
          state_d        = ST_RESP;
          read_d         = 1'b0;
          write_d        = 1'b0;
          rsp_valid_d    = 1'b1;
          rsp_readdata_d = dir_write_q ? {WIDTHD{1'b0}} : readdata;
        end else if (timeout_s) begin
          state_d        = ST_RESP;
          read_d         = 1'b0;
          write_d        = 1'b0;
          rsp_valid_d    = 1'b1;
          rsp_readdata_d = {WIDTHD{1'b0}};
        end else begin
          state_d = ST_BUS;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        read_d      = 1'b0;
        write_d     = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      state_q        <= ST_IDLE;
      cmd_ready_q    <= 1'b1;
      dir_write_q    <= 1'b0;
      read_q         <= 1'b0;
      write_q        <= 1'b0;
      address_q      <= {WIDTHA{1'b0}};
      writedata_q    <= {WIDTHD{1'b0}};
      rsp_valid_q    <= 1'b0;
      rsp_readdata_q <= {WIDTHD{1'b0}};
    end else begin
      state_q        <= state_d;
      cmd_ready_q    <= cmd_ready_d;
      dir_write_q    <= dir_write_d;
      read_q         <= read_d;
      write_q        <= write_d;
      address_q      <= address_d;
      writedata_q    <= writedata_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_readdata_q <= rsp_readdata_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign read         = read_q;
  assign write        = write_q;
  assign address      = address_q;
  assign writedata    = writedata_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_readdata = rsp_readdata_q;
endmodule

// File: tb/tb_micro_bus_initiator.sv
// Bench for micro_bus_initiator: directed latency/handshake cases plus random traffic,
// checked against a transaction-level register-file model and a wait-state responder.
module tb_micro_bus_initiator;
  localparam int TO = 4;
`ifdef MICRO_BUS_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clock_sreset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_address;
  logic [31:0] cmd_writedata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_readdata;
  logic [3:0]  address;
  logic [31:0] writedata, readdata;
  logic        read, write, waitrequest;

  always #5 clock = ~clock;

  micro_bus_initiator #(.WIDTHD(32), .WIDTHA(4), .TIMEOUT(TO)) dut (
    .clock(clock), .clock_sreset(clock_sreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_readdata(rsp_readdata),
    .rsp_error(rsp_error), .address(address), .writedata(writedata),
    .readdata(readdata), .read(read), .write(write), .waitrequest(waitrequest)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] model_mem [16];
  logic [31:0] resp_mem [16];
  logic [31:0] exp_data [$];
  logic        exp_err [$];
  logic        cur_wr;
  logic [3:0]  cur_addr;
  logic [31:0] cur_wdata;
  int          cur_waits;
  logic        inflight;
  int          age;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%b required=%b", name, act, req);
    end
  endtask

  // Responder: register file behind the bus, stalls each transfer for cur_waits cycles.
  task automatic responder();
    forever begin
      @(negedge clock);
      if (write && !waitrequest && !clock_sreset) resp_mem[address] = writedata;
      @(posedge clock);
      #1;
      if (read || write) begin
        waitrequest = (age < cur_waits);
        age++;
      end else begin
        waitrequest = 1'b0;
        age = 0;
      end
      readdata = read ? resp_mem[address] : 32'hDEAD_BEEF;
    end
  endtask

  // Every-cycle compare: bus strobes belong to the in-flight command, responses match the model.
  task automatic checker_loop();
    logic seen = 1'b0;
    forever begin
      @(negedge clock);
      if (!clock_sreset) begin
        chk1("strobe_exclusive", read & write, 1'b0);
        if (read || write) begin
          chk1("strobe_owned", inflight, 1'b1);
          chk1("bus_dir", write, cur_wr);
          chk32("bus_addr", 32'(address), 32'(cur_addr));
          if (cur_wr) chk32("bus_wdata", writedata, cur_wdata);
          seen = 1'b1;
        end else if (seen) begin
          inflight = 1'b0;
          seen = 1'b0;
        end
        if (rsp_valid) begin
          chk1("rsp_pending", exp_data.size() > 0, 1'b1);
          if (exp_data.size() > 0) begin
            chk32("rsp_readdata", rsp_readdata, exp_data[0]);
            chk1("rsp_error", rsp_error, exp_err[0]);
            if (rsp_ready) begin
              void'(exp_data.pop_front());
              void'(exp_err.pop_front());
            end
          end
        end
      end else begin
        seen = 1'b0;
      end
    end
  endtask

  // Waits for cmd_ready, records the expected response, and presents the command for one accept edge.
  task automatic issue(input logic wr, input logic [3:0] a, input logic [31:0] d,
                       input int waits, input bit rnd_ready);
    int guard = 0;
    while (!cmd_ready && guard < 100) begin
      if (rnd_ready) rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock);
      #1;
      guard++;
    end
    chk1("cmd_ready_wait", cmd_ready, 1'b1);
    cur_wr = wr; cur_addr = a; cur_wdata = d; cur_waits = waits; inflight = 1'b1;
    if (TO_ON && waits >= TO) begin
      exp_data.push_back(32'h0); exp_err.push_back(1'b1);
    end else if (wr) begin
      model_mem[a] = d;
      exp_data.push_back(32'h0); exp_err.push_back(1'b0);
    end else begin
      exp_data.push_back(model_mem[a]); exp_err.push_back(1'b0);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_address = a; cmd_writedata = d;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    cmd_writedata = 32'h5A5A_5A5A;
    if (rnd_ready) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic        wr;
    logic [3:0]  a;
    logic [31:0] d;
    int          w;
    int          guard;
    clock_sreset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = 4'h0;
    cmd_writedata = 32'h0; rsp_ready = 1'b1; readdata = 32'h0; waitrequest = 1'b0;
    inflight = 1'b0; age = 0; cur_waits = 0; cur_wr = 1'b0; cur_addr = 4'h0; cur_wdata = 32'h0;
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = 32'hA500_0000 + 32'(i);
      resp_mem[i]  = 32'hA500_0000 + 32'(i);
    end
    fork
      responder();
      checker_loop();
    join_none

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk1("rst_read", read, 1'b0);
    chk1("rst_write", write, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rsp_error", rsp_error, 1'b0);
    chk32("rst_address", 32'(address), 32'h0);
    chk32("rst_writedata", writedata, 32'h0);
    chk32("rst_rsp_readdata", rsp_readdata, 32'h0);
    chk1("rst_cmd_ready", cmd_ready, 1'b1);
    @(posedge clock);
    #1;
    clock_sreset = 1'b0;

    // Zero-wait write: strobe at N+1 only, response at N+2.
    issue(1'b1, 4'h0, 32'h7, 0, 1'b0);
    @(negedge clock);
    chk1("w_n1_write", write, 1'b1);
    chk1("w_n1_rsp_valid", rsp_valid, 1'b0);
    @(negedge clock);
    chk1("w_n2_write", write, 1'b0);
    chk1("w_n2_rsp_valid", rsp_valid, 1'b1);
    chk32("w_n2_rsp_readdata", rsp_readdata, 32'h0);
    chk1("w_n2_rsp_error", rsp_error, 1'b0);

    // One-wait read of 0x1234: strobe two cycles, data at N+3.
    issue(1'b1, 4'h2, 32'h0000_1234, 0, 1'b0);
    issue(1'b0, 4'h2, 32'h0, 1, 1'b0);
    @(negedge clock);
    chk1("r_n1_read", read, 1'b1);
    @(negedge clock);
    chk1("r_n2_read", read, 1'b1);
    chk1("r_n2_rsp_valid", rsp_valid, 1'b0);
    @(negedge clock);
    chk1("r_n3_read", read, 1'b0);
    chk1("r_n3_rsp_valid", rsp_valid, 1'b1);
    chk32("r_n3_rsp_readdata", rsp_readdata, 32'h0000_1234);

    // Response back-pressure with a competing command that must not be taken.
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    issue(1'b1, 4'h5, 32'hCAFE_0005, 0, 1'b0);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 4'h3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk1("bp_rsp_valid", rsp_valid, 1'b1);
      chk32("bp_rsp_readdata", rsp_readdata, 32'h0);
      chk1("bp_cmd_ready", cmd_ready, 1'b0);
      chk1("bp_read", read, 1'b0);
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk1("bp_after_rsp_valid", rsp_valid, 1'b0);
    chk1("bp_after_cmd_ready", cmd_ready, 1'b1);
    chk1("bp_after_read", read, 1'b0);

`ifdef MICRO_BUS_TIMEOUT_EN
    // Stuck waitrequest: read drops after TIMEOUT stalled cycles with an error response.
    issue(1'b0, 4'h1, 32'h0, 1000, 1'b0);
    for (int i = 0; i < TO; i++) begin
      @(negedge clock);
      chk1("to_read_high", read, 1'b1);
    end
    @(negedge clock);
    chk1("to_read_low", read, 1'b0);
    chk1("to_rsp_valid", rsp_valid, 1'b1);
    chk1("to_rsp_error", rsp_error, 1'b1);
    chk32("to_rsp_readdata", rsp_readdata, 32'h0);
    issue(1'b0, 4'h1, 32'h0, TO - 1, 1'b0);
    for (int i = 0; i < TO; i++) begin
      @(negedge clock);
      chk1("to_edge_read_high", read, 1'b1);
    end
    @(negedge clock);
    chk1("to_edge_rsp_error", rsp_error, 1'b0);
    chk32("to_edge_rsp_readdata", rsp_readdata, 32'hA500_0001);
`else
    // Long stall without watchdog still completes normally.
    issue(1'b0, 4'h1, 32'h0, 8, 1'b0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      chk1("long_read_high", read, 1'b1);
    end
    @(negedge clock);
    chk1("long_rsp_valid", rsp_valid, 1'b1);
    chk1("long_rsp_error", rsp_error, 1'b0);
    chk32("long_rsp_readdata", rsp_readdata, 32'hA500_0001);
`endif

    // Reset in the middle of a stalled read discards it without a response.
    issue(1'b0, 4'h6, 32'h0, 20, 1'b0);
    @(negedge clock);
    chk1("srst_pre_read", read, 1'b1);
    @(posedge clock);
    #1;
    clock_sreset = 1'b1;
    @(posedge clock);
    #1;
    clock_sreset = 1'b0;
    exp_data.delete();
    exp_err.delete();
    inflight = 1'b0;
    @(negedge clock);
    chk1("srst_read", read, 1'b0);
    chk1("srst_cmd_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk1("srst_no_rsp", rsp_valid, 1'b0);
    end

    // Random back-to-back traffic with 0-3 wait cycles and random response back-pressure.
    @(posedge clock);
    #1;
    for (int n = 0; n < 100; n++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      d  = $urandom;
      w  = int'($urandom_range(0, 3));
      issue(wr, a, d, w, 1'b1);
    end
    rsp_ready = 1'b1;
    guard = 0;
    while (exp_data.size() > 0 && guard < 50) begin
      @(posedge clock);
      #1;
      guard++;
    end
    chk32("drain_pending", 32'(exp_data.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/micro_bus_initiator.md
MICRO_BUS_INITIATOR -- requirements
Module: micro_bus_initiator

Interface
REQ-001 SHALL have parameter WIDTHD, default 32, data width of command, response and bus data.
REQ-002 SHALL have parameter WIDTHA, default 4, bus address width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum waitrequest-high cycles per transfer (1..65535).
REQ-004 SHALL have port clock  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port clock_sreset  input  1  synchronous reset, active-high.
REQ-006 SHALL have port cmd_valid  input  1  command request from core.
REQ-007 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-008 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port cmd_address  input  WIDTHA  target register address.
REQ-010 SHALL have port cmd_writedata  input  WIDTHD  write payload.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  core accepts response.
REQ-013 SHALL have port rsp_readdata  output  WIDTHD  read result; 0 for writes and errors.
REQ-014 SHALL have port rsp_error  output  1  transfer aborted by timeout.
REQ-015 SHALL have ports address (output, WIDTHA), writedata (output, WIDTHD), readdata (input, WIDTHD), read (output, 1), write (output, 1), waitrequest (input, 1): bus initiator side.

Function
REQ-016 SHALL implement states IDLE, BUS, RESP; cmd_ready = 1 only in IDLE.
REQ-017 SHALL, on cmd_valid & cmd_ready in cycle N, register address/data/direction and enter BUS, asserting read or write from cycle N+1.
REQ-018 SHALL hold address, writedata and read/write stable while in BUS and waitrequest = 1.
REQ-019 SHALL complete the transfer in the first BUS cycle with waitrequest = 0, capture readdata in that cycle for reads, deassert read/write next cycle, enter RESP.
REQ-020 SHALL never assert read and write together; never assert either outside BUS.
REQ-021 SHALL assert rsp_valid throughout RESP with rsp_readdata/rsp_error stable; on rsp_valid & rsp_ready return to IDLE next cycle.
REQ-022 SHALL give minimum latency: accept N, strobe N+1, rsp_valid N+2 when waitrequest = 0 at N+1.
REQ-023 SHALL produce a response (rsp_readdata = 0, rsp_error = 0) for every successful write.
REQ-024 SHALL ignore cmd_valid when not in IDLE; a command is consumed exactly once.
REQ-025 SHALL keep rsp_valid low outside RESP; cmd_valid in the cycle RESP exits is accepted only from the following IDLE cycle.

Reset
REQ-026 SHALL, on clock_sreset, enter IDLE; read, write, rsp_valid, rsp_error = 0; address, writedata, rsp_readdata = 0; timeout counter = 0.
REQ-027 SHALL, on reset during BUS or RESP, drop strobes and rsp_valid the next cycle and discard the pending transfer with no response.

Configuration
REQ-028 SHALL compile the timeout watchdog only when macro MICRO_BUS_TIMEOUT_EN is defined.
REQ-029 SHALL, with MICRO_BUS_TIMEOUT_EN, count BUS cycles with waitrequest = 1 (counter cleared on command accept); when the count reaches TIMEOUT, deassert strobe next cycle, enter RESP with rsp_error = 1, rsp_readdata = 0.
REQ-030 SHALL, with MICRO_BUS_TIMEOUT_EN, treat waitrequest = 0 in the same cycle the count reaches TIMEOUT as success (completion wins).
REQ-031 SHALL, without MICRO_BUS_TIMEOUT_EN, wait indefinitely in BUS, tie rsp_error to 0, and contain no counter logic.

Verification
REQ-032 SHALL cover write addr 0x0 data 0x7, responder waitrequest = 0 -> write high exactly 1 cycle at N+1, rsp_valid at N+2, rsp_readdata = 0, rsp_error = 0.
REQ-033 SHALL cover read addr 0x2, responder 1 wait cycle returning 0x0000_1234 -> read high 2 cycles, rsp_readdata = 0x0000_1234 at N+3.
REQ-034 SHALL cover rsp_ready held low 5 cycles -> rsp_valid and data stable 5 cycles, cmd_ready = 0, second cmd_valid not consumed.
REQ-035 SHALL cover (timeout on, TIMEOUT = 4) waitrequest stuck high -> read drops after 4 wait cycles, rsp_error = 1, rsp_readdata = 0.
REQ-036 SHALL cover clock_sreset asserted mid-BUS with waitrequest = 1 -> read = 0 and state IDLE next cycle, no rsp_valid ever for that command.
REQ-037 SHALL cover 100 random back-to-back read/write commands with random 0-3 wait cycles -> read data matches responder model, no overlapping strobes.
